// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between NREQ byte/pair read requesters
// and a CPU write port. Writes win in IDLE; reads are granted round-robin.
module vram_arbiter #(
  parameter int NREQ = 5,
  parameter int AW   = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_pair,
  output logic [NREQ-1:0]    req_grant,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [15:0]        rsp_data,
  input  logic               wr_req,
  input  logic [AW-1:0]      wr_addr,
  input  logic [7:0]         wr_data,
  output logic               wr_ack,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, HI} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [AW-1:0]   hi_addr;
  logic [AW-1:0]   mem_addr_q;
  logic [15:0]     rsp_data_q;

  logic            sgl_vld_p1, pr_vld_p1, pr_vld_p2;
  logic [PW-1:0]   id_p1, id_p2;
  logic [7:0]      lo_p2;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [AW-1:0]   sel_addr;
  logic            do_wr, do_rd;

  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  assign sel_addr = req_addr[int'(win_idx)*AW +: AW];
  assign do_wr    = !reset && (state == IDLE) && wr_req;
  assign do_rd    = !reset && (state == IDLE) && !wr_req && win_found;

  // Stage p0: memory port issue (grant, write, or second byte of a pair)
  always_comb begin
    req_grant = '0;
    if (do_rd) req_grant[win_idx] = 1'b1;
    wr_ack    = do_wr;
    mem_we    = do_wr;
    mem_wdata = wr_data;
    mem_addr  = mem_addr_q;
    if (do_wr)                        mem_addr = wr_addr;
    else if (do_rd)                   mem_addr = sel_addr;
    else if (!reset && state == HI)   mem_addr = hi_addr;
    busy = (state == HI);
  end

  // Stage p1/p2: responses assembled from the live RAM output
  always_comb begin
    rsp_valid = '0;
    rsp_data  = rsp_data_q;
    if (!reset && sgl_vld_p1) begin
      rsp_valid[id_p1] = 1'b1;
      rsp_data         = {8'h00, mem_rdata};
    end else if (!reset && pr_vld_p2) begin
      rsp_valid[id_p2] = 1'b1;
      rsp_data         = {mem_rdata, lo_p2};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      sgl_vld_p1 <= 1'b0;
      pr_vld_p1  <= 1'b0;
      pr_vld_p2  <= 1'b0;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      mem_addr_q <= mem_addr;
      rsp_data_q <= rsp_data;
      sgl_vld_p1 <= do_rd && !req_pair[win_idx];
      pr_vld_p1  <= do_rd && req_pair[win_idx];
      pr_vld_p2  <= pr_vld_p1;
      if (do_rd) begin
        rr_ptr <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        if (req_pair[win_idx]) state <= HI;
      end else if (state == HI) begin
        state <= IDLE;
      end
    end
  end

  // Datapath registers carry no reset; their valids qualify them
  always_ff @(posedge clk) begin
    if (do_rd) begin
      id_p1   <= win_idx;
      hi_addr <= sel_addr + 1'b1;
    end
    if (pr_vld_p1) begin
      lo_p2 <= mem_rdata;
      id_p2 <= id_p1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus randomized traffic, all
// compared each cycle against a spec-level reference model and a VRAM shadow.
module tb_vram_arbiter;
  localparam int NREQ  = 5;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NREQ-1:0]     req_valid, req_pair, req_grant, rsp_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [15:0]         rsp_data;
  logic                wr_req, wr_ack, mem_we, busy;
  logic [AW-1:0]       wr_addr, mem_addr;
  logic [7:0]          wr_data, mem_wdata, mem_rdata;

  vram_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_pair(req_pair),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Read-first synchronous VRAM with a backdoor load port
  logic [7:0]    vram [DEPTH];
  logic          bk_we;
  logic [AW-1:0] bk_addr;
  logic [7:0]    bk_data;
  always @(posedge clk) begin
    mem_rdata <= vram[mem_addr];
    if (mem_we)     vram[mem_addr] <= mem_wdata;
    else if (bk_we) vram[bk_addr]  <= bk_data;
  end

  typedef struct {int cyc; int id; logic [15:0] d;} sb_t;

  logic [7:0]    ref_mem [DEPTH];
  sb_t           sb [$];
  logic          m_hi;
  logic [AW-1:0] m_hi_addr, m_last;
  logic [15:0]   m_hold;
  int            m_rr;
  int            cyc = 0;

  logic          rv [NREQ];
  logic          rp [NREQ];
  logic          sticky [NREQ];
  logic [AW-1:0] ra [NREQ];
  logic          wp, rst, rand_on;
  logic [AW-1:0] wa;
  logic [7:0]    wd;

  logic [NREQ-1:0] obs_g, obs_v;
  logic [15:0]     obs_d;
  logic [AW-1:0]   obs_a;
  logic            obs_b, obs_wa, obs_we;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom % 4 == 0) return 13'h1FFF;
    return AW'($urandom % 32);
  endfunction

  task automatic cycle();
    logic [NREQ-1:0] eg, ev;
    logic            ewa, eb;
    logic [AW-1:0]   a, a1;
    logic [15:0]     ed;
    int              g, c;
    eg = '0; ev = '0; ewa = 1'b0; eb = 1'b0; a = m_last; ed = m_hold; g = -1;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = rv[i];
      req_pair[i]  = rp[i];
      req_addr[i*AW +: AW] = ra[i];
    end
    wr_req = wp; wr_addr = wa; wr_data = wd; reset = rst;
    #1;
    obs_g = req_grant; obs_v = rsp_valid; obs_d = rsp_data; obs_a = mem_addr;
    obs_b = busy; obs_wa = wr_ack; obs_we = mem_we;
    if (rst) begin
      chk("reset_grant", obs_g, 0);
      chk("reset_rsp_valid", obs_v, 0);
      chk("reset_wr_ack", obs_wa, 0);
      chk("reset_mem_we", obs_we, 0);
    end else begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev[sb[0].id] = 1'b1;
        ed = sb[0].d;
        m_hold = ed;
        void'(sb.pop_front());
      end
      if (m_hi) begin
        a = m_hi_addr; eb = 1'b1;
      end else if (wp) begin
        ewa = 1'b1; a = wa;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_rr + k) % NREQ;
          if (g < 0 && rv[c]) g = c;
        end
        if (g >= 0) begin eg[g] = 1'b1; a = ra[g]; end
      end
      chk("rsp_valid", obs_v, ev);
      chk("rsp_data", obs_d, ed);
      chk("req_grant", obs_g, eg);
      chk("wr_ack", obs_wa, ewa);
      chk("mem_we", obs_we, ewa);
      chk("busy", obs_b, eb);
      chk("mem_addr", obs_a, a);
      if (ewa) chk("mem_wdata", mem_wdata, wd);
    end
    @(posedge clk);
    if (rst) begin
      m_hi = 1'b0; m_rr = 0; m_last = '0; m_hold = '0; sb.delete();
    end else begin
      m_last = a;
      if (m_hi) m_hi = 1'b0;
      else if (ewa) begin ref_mem[wa] = wd; wp = 1'b0; end
      else if (g >= 0) begin
        m_rr = (g + 1) % NREQ;
        a1 = ra[g] + 1'b1;
        if (rp[g]) begin
          m_hi = 1'b1; m_hi_addr = a1;
          sb.push_back('{cyc + 2, g, {ref_mem[a1], ref_mem[ra[g]]}});
        end else begin
          sb.push_back('{cyc + 1, g, {8'h00, ref_mem[ra[g]]}});
        end
        if (!sticky[g]) rv[g] = 1'b0;
      end
    end
    cyc++;
    if (rand_on) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && ($urandom % 2 == 0)) begin
          rv[i] = 1'b1; rp[i] = 1'($urandom % 2); ra[i] = rand_addr();
        end
      if (!wp && ($urandom % 6 == 0)) begin
        wp = 1'b1; wa = rand_addr(); wd = 8'($urandom);
      end
      rst = ($urandom % 200 == 0);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d; ref_mem[a] = d;
    cycle();
    bk_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rand_on = 1'b0; wp = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0; rp[i] = 1'b0; sticky[i] = 1'b0; ra[i] = '0;
    end
    m_hi = 1'b0; m_rr = 0; m_last = '0; m_hold = '0; m_hi_addr = '0;
    reset = 1'b1; req_valid = '0; req_pair = '0; req_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bk_we = 1'b1; bk_addr = AW'(i); bk_data = 8'($urandom); ref_mem[i] = bk_data;
    end
    @(negedge clk);
    bk_we = 1'b0;

    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("after_reset_grant", obs_g, 0);
    chk("after_reset_busy", obs_b, 0);
    chk("after_reset_mem_we", obs_we, 0);
    chk("after_reset_mem_addr", obs_a, 0);
    chk("after_reset_rsp_data", obs_d, 0);

    // single read
    poke(13'h0010, 8'h3C);
    rv[2] = 1'b1; ra[2] = 13'h0010; rp[2] = 1'b0;
    cycle();
    chk("single_grant", obs_g, 5'b00100);
    chk("single_addr", obs_a, 13'h0010);
    cycle();
    chk("single_rsp_valid", obs_v, 5'b00100);
    chk("single_rsp_data", obs_d, 16'h003C);
    cycle();
    chk("single_hold", obs_d, 16'h003C);

    // pair read wrapping the top of VRAM
    poke(13'h1FFF, 8'hAA);
    poke(13'h0000, 8'h55);
    rv[1] = 1'b1; ra[1] = 13'h1FFF; rp[1] = 1'b1;
    cycle();
    chk("pair_grant", obs_g, 5'b00010);
    chk("pair_addr_lo", obs_a, 13'h1FFF);
    cycle();
    chk("pair_busy", obs_b, 1);
    chk("pair_addr_hi", obs_a, 13'h0000);
    chk("pair_hi_no_grant", obs_g, 0);
    cycle();
    chk("pair_rsp_valid", obs_v, 5'b00010);
    chk("pair_rsp_data", obs_d, 16'h55AA);
    rp[1] = 1'b0;

    // reset during HI
    rv[3] = 1'b1; ra[3] = 13'h0100; rp[3] = 1'b1;
    cycle();
    chk("rmp_grant", obs_g, 5'b01000);
    rst = 1'b1;
    cycle();
    rst = 1'b0; rp[3] = 1'b0;
    rv[0] = 1'b1; ra[0] = 13'h0010; rp[0] = 1'b0;
    rv[4] = 1'b1; ra[4] = 13'h1FFF; rp[4] = 1'b0;
    cycle();
    chk("rmp_first_grant", obs_g, 5'b00001);
    chk("rmp_no_rsp", obs_v, 0);
    cycle();
    chk("rmp_second_grant", obs_g, 5'b10000);
    chk("rmp_rsp0_valid", obs_v, 5'b00001);
    chk("rmp_rsp0_data", obs_d, 16'h003C);
    cycle();
    chk("rmp_rsp4_data", obs_d, 16'h00AA);

    // round robin with everyone requesting continuously
    for (int i = 0; i < NREQ; i++) begin
      sticky[i] = 1'b1; rv[i] = 1'b1; rp[i] = 1'b0; ra[i] = AW'(i * 16);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_grant", obs_g, 1 << (k % NREQ));
      if (k > 0) chk("rr_rsp", obs_v, 1 << ((k - 1) % NREQ));
    end
    for (int i = 0; i < NREQ; i++) begin sticky[i] = 1'b0; rv[i] = 1'b0; end
    cycle(); cycle();

    // write arriving during HI waits, then read-after-write
    rv[1] = 1'b1; ra[1] = 13'h0200; rp[1] = 1'b1;
    cycle();
    chk("wh_pair_grant", obs_g, 5'b00010);
    wp = 1'b1; wa = 13'h0300; wd = 8'hA5;
    rv[2] = 1'b1; ra[2] = 13'h0300; rp[2] = 1'b0;
    cycle();
    chk("wh_hi_no_ack", obs_wa, 0);
    chk("wh_hi_busy", obs_b, 1);
    cycle();
    chk("wh_ack", obs_wa, 1);
    chk("wh_we", obs_we, 1);
    chk("wh_addr", obs_a, 13'h0300);
    chk("wh_no_grant", obs_g, 0);
    chk("wh_pair_rsp", obs_v, 5'b00010);
    cycle();
    chk("raw_grant", obs_g, 5'b00100);
    cycle();
    chk("raw_rsp_valid", obs_v, 5'b00100);
    chk("raw_rsp_data", obs_d, 16'h00A5);
    rp[1] = 1'b0;

    // idle stretch leaves the round-robin pointer alone
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("idle_we", obs_we, 0);
      chk("idle_grant", obs_g, 0);
    end
    for (int i = 0; i < NREQ; i++) begin rv[i] = 1'b1; ra[i] = AW'(i); end
    cycle();
    chk("idle_rr_kept", obs_g, 5'b01000);
    repeat (8) cycle();

    // randomized traffic
    rand_on = 1'b1;
    repeat (3000) cycle();
    rand_on = 1'b0; rst = 1'b0;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Time-multiplexes one single-port VRAM (8 KiB, synchronous read, 1-cycle latency) between N PPU/CPU read requesters and one CPU write port.
- Replaces the per-fetcher duplicated VRAM copies; each fetcher requests a byte or a byte pair (tile row lo/hi at addr, addr+1).
- Sits between the mmu/ppu and a single VRAM instance, all clocked on gb_clk.

Parameters:
- NREQ, 5, number of read requesters (index 0 = CPU read, 1..NREQ-1 = PPU fetchers).
- AW, 13, VRAM address width; all address arithmetic is modulo 2^AW.

Ports:
- clk  in  1  system clock (gb_clk domain).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester read request, held until granted.
- req_addr  in  NREQ*AW  packed byte addresses; requester i uses bits [i*AW +: AW].
- req_pair  in  NREQ  1 = read addr and addr+1; 0 = single byte.
- req_grant  out  NREQ  one-hot pulse; the request is consumed in that cycle.
- rsp_valid  out  NREQ  one-hot pulse; rsp_data is valid for that requester.
- rsp_data  out  16  {hi,lo}; hi = 8'h00 for single reads.
- wr_req  in  1  CPU write request, held until accepted.
- wr_addr  in  AW  write address.
- wr_data  in  8  write data.
- wr_ack  out  1  pulse; the write is performed in this cycle.
- mem_addr  out  AW  VRAM address.
- mem_we  out  1  VRAM write enable.
- mem_wdata  out  8  VRAM write data.
- mem_rdata  in  8  VRAM read data, valid 1 cycle after address.
- busy  out  1  high while a pair read is in progress (state HI).

Behaviour:
- Reset: state IDLE, rr_ptr=0, req_grant=0, rsp_valid=0, rsp_data=0, wr_ack=0, mem_we=0, mem_addr=0, busy=0. In-flight accesses are dropped; no rsp_valid is issued for them after reset.
- FSM states:
  - IDLE: the memory port is free this cycle.
  - HI: the second address of a pair is issued this cycle.
- IDLE priority:
  - (1) wr_req: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data, wr_ack=1; no read grant this cycle.
  - (2) Otherwise round-robin over req_valid, starting at rr_ptr and ascending with wrap. The winner g gets req_grant[g]=1 and mem_addr=addr_g; rr_ptr <= (g+1) mod NREQ.
  - If req_pair[g], latch g and addr_g+1 and go to HI; otherwise stay in IDLE.
  - With no request, mem_we=0, mem_addr holds its previous value, and rr_ptr is unchanged.
- HI: mem_addr=latched addr+1 (wraps 2^AW-1 -> 0), busy=1, no grants, wr_ack=0, then return to IDLE. A pending write waits.
- Response timing, for a grant in cycle T:
  - Single read: rsp_valid[g]=1 at T+1 with rsp_data={8'h00,mem_rdata}.
  - Pair read: lo is captured at T+1; rsp_valid[g]=1 at T+2 with rsp_data={mem_rdata,lo}.
  - rsp_data holds its value until the next rsp_valid.
- Throughput: single reads can be granted every cycle, and pairs every 2 cycles. A write occupies 1 IDLE cycle. At most one memory operation is performed per cycle.
- A requester may deassert req_valid only after its grant. The arbiter samples req_addr and req_pair only in the grant cycle.
- A grant and a response to different requesters may occur in the same cycle. A response to g and a new grant to g may also coincide.
- Read-after-write: a read granted in the cycle after wr_ack returns the new data, because the RAM is read-first per cycle and the write has completed.
- Starvation bound: with all requesters active, each read is granted within NREQ grants. Continuous wr_req may starve reads; the CPU issues at most one write per 4 cycles by construction.

Test Plan:
- Single read: after reset, req_valid[2]=1, req_addr[2]=0x0010, VRAM[0x10]=0x3C -> req_grant[2] at T, rsp_valid[2] at T+1, rsp_data=0x003C.
- Pair read with wrap: req_pair[1]=1, addr=0x1FFF, VRAM[0x1FFF]=0xAA, VRAM[0x0000]=0x55 -> mem_addr 0x1FFF then 0x0000, busy=1 at T+1, rsp_data=0x55AA at T+2.
- Round robin: all 5 requesters issue single reads continuously -> grants 0,1,2,3,4,0 on consecutive cycles, with each rsp_valid one cycle after its grant.
- Write priority and stall: wr_req is asserted during HI of a pair -> wr_ack in the following IDLE cycle, not during HI. A read of the same address next cycle returns wr_data.
- Reset mid-pair: assert reset in the HI cycle -> no rsp_valid afterwards, rr_ptr=0, and a subsequent single read to requester 0 is granted first.
- Idle: no requests for 10 cycles -> mem_we=0, no grants, rr_ptr unchanged.
